kmeans_result_sink: RTL

Downstream stage of the k-means clustering engine. It captures the four-word centroid burst the engine emits on `out_valid`/`out_data` and buffers it. It replays the centroids to the host over a valid/ready stream, tagging each word with its cluster index and marking the last word. It also flags malformed or overrunning bursts and, optionally, measures engine latency from job start to first result.

---
 rtl/kmeans_result_sink_if.sv | 30 +++
 rtl/kmeans_result_sink.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/kmeans_result_sink_if.sv
// Host/engine-facing bundle of kmeans_result_sink: result capture, replay stream, errors, latency.
// slave is the sink's view; master is the engine/host side driving it.
interface kmeans_result_sink_if #(
    parameter int DATA_W = 16,
    parameter int LAT_W  = 24
);
    logic              in_start;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_idx;
    logic              m_last;
    logic              err_clr;
    logic              err_short;
    logic              err_overrun;
    logic              lat_valid;
    logic [LAT_W-1:0]  latency;

    modport slave (
        input  in_start, res_valid, res_data, m_ready, err_clr,
        output m_valid, m_data, m_idx, m_last, err_short, err_overrun, lat_valid, latency
    );

    modport master (
        output in_start, res_valid, res_data, m_ready, err_clr,
        input  m_valid, m_data, m_idx, m_last, err_short, err_overrun, lat_valid, latency
    );
endinterface

// File: rtl/kmeans_result_sink.sv
// Buffers a 4-word centroid burst and replays it indexed; m_valid rises 1 cycle after the last word.
// Stream held under m_ready=0, words arriving mid-drain are dropped; KMEANS_SINK_LATENCY_EN adds latency timer.
module kmeans_result_sink #(
    parameter int NUM_CLUSTERS = 4,
    parameter int DATA_W       = 16,
    parameter int LAT_W        = 24
) (
    input  logic               clk,
    input  logic               rst,
    kmeans_result_sink_if.slave bus
);
    localparam logic [1:0] LAST_IDX = 2'(NUM_CLUSTERS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_buf [NUM_CLUSTERS];
    logic [1:0]        r_wcnt;
    logic [1:0]        r_rcnt;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [1:0]        r_m_idx;
    logic              r_m_last;
    logic              r_err_short;
    logic              r_err_overrun;

    logic       w_hs;
    logic       w_wr_en;
    logic [1:0] w_wr_addr;
    logic [1:0] w_next_idx;
    logic       w_short_set;
    logic       w_ovr_set;

    assign w_hs        = r_m_valid & bus.m_ready;
    assign w_wr_en     = bus.res_valid & (r_state != DRAIN);
    assign w_wr_addr   = (r_state == IDLE) ? 2'd0 : r_wcnt;
    assign w_next_idx  = r_rcnt + 2'd1;
    assign w_short_set = (r_state == CAPTURE) & ~bus.res_valid;
    assign w_ovr_set   = (r_state == DRAIN) & bus.res_valid;

    // Buffer contents are never presented outside DRAIN, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_addr] <= bus.res_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wcnt    <= 2'd0;
            r_rcnt    <= 2'd0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_idx   <= 2'd0;
            r_m_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.res_valid) begin
                        r_wcnt  <= 2'd1;
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.res_valid) begin
                        if (r_wcnt == LAST_IDX) begin
                            r_state   <= DRAIN;
                            r_wcnt    <= 2'd0;
                            r_rcnt    <= 2'd0;
                            r_m_valid <= 1'b1;
                            r_m_data  <= r_buf[0];
                            r_m_idx   <= 2'd0;
                            r_m_last  <= 1'b0;
                        end else begin
                            r_wcnt <= r_wcnt + 2'd1;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_wcnt  <= 2'd0;
                    end
                end
                DRAIN: begin
                    // Next word is preloaded on each handshake so outputs stay pure registers.
                    if (w_hs) begin
                        if (r_rcnt == LAST_IDX) begin
                            r_state   <= IDLE;
                            r_rcnt    <= 2'd0;
                            r_m_valid <= 1'b0;
                            r_m_data  <= '0;
                            r_m_idx   <= 2'd0;
                            r_m_last  <= 1'b0;
                        end else begin
                            r_rcnt   <= w_next_idx;
                            r_m_data <= r_buf[w_next_idx];
                            r_m_idx  <= w_next_idx;
                            r_m_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_short   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_short   <= w_short_set | (r_err_short & ~bus.err_clr);
            r_err_overrun <= w_ovr_set | (r_err_overrun & ~bus.err_clr);
        end
    end

    assign bus.m_valid     = r_m_valid;
    assign bus.m_data      = r_m_data;
    assign bus.m_idx       = r_m_idx;
    assign bus.m_last      = r_m_last;
    assign bus.err_short   = r_err_short;
    assign bus.err_overrun = r_err_overrun;

`ifdef KMEANS_SINK_LATENCY_EN
    logic             r_armed;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] r_latency;
    logic             r_lat_valid;

    // Counter holds the cycle distance of the current cycle from in_start, hence the load of 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_latency   <= '0;
            r_lat_valid <= 1'b0;
        end else begin
            r_lat_valid <= 1'b0;
            if (bus.in_start) begin
                r_armed <= 1'b1;
                r_cnt   <= LAT_W'(1);
            end else if (r_armed) begin
                if (bus.res_valid) begin
                    r_latency   <= r_cnt;
                    r_lat_valid <= 1'b1;
                    r_armed     <= 1'b0;
                end else if (r_cnt != {LAT_W{1'b1}}) begin
                    r_cnt <= r_cnt + LAT_W'(1);
                end
            end
        end
    end

    assign bus.lat_valid = r_lat_valid;
    assign bus.latency   = r_latency;
`else
    logic w_unused_in_start;

    assign w_unused_in_start = bus.in_start;
    assign bus.lat_valid     = 1'b0;
    assign bus.latency       = '0;
`endif
endmodule
